// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//   Turns the GMII receive stream into an 8-bit AXI-Stream of frame bytes.
//   It strips the preamble and SFD and checks the length and the CRC-32 FCS.
//   It also counts good frames and bad or dropped frames.
//
//   Build option: `GMII_RX_FCS_STRIP_EN
//     defined   -> 5-byte hold pipeline; the 4 FCS bytes are not emitted.
//     undefined -> 1-byte hold pipeline; the FCS bytes are the last 4 beats.
//
//   Ports
//     userclk2       125 MHz GMII receive clock (only clock)
//     reset          synchronous, active-high
//     gmii_rxd       receive data
//     gmii_rx_dv     receive data valid
//     gmii_rx_er     receive error
//     m_axis_tdata   payload byte
//     m_axis_tvalid  beat valid (no backpressure)
//     m_axis_tlast   last beat of a frame
//     m_axis_tuser   frame bad, meaningful on the tlast beat
//     frames_ok      saturating count of good frames
//     frames_bad     saturating count of bad or dropped frames
module gmii_rx_deframer #(
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic        userclk2,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

`ifdef GMII_RX_FCS_STRIP_EN
  localparam int unsigned D = 5;
`else
  localparam int unsigned D = 1;
`endif
  localparam int unsigned OLD         = D - 1;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_INIT    = '1;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t      state, state_nxt;
  logic        push, frame_end, drop_enter;
  logic        frame_bad;

  logic [7:0]  pipe [D];
  logic [15:0] len;
  logic [31:0] len_ext;
  logic [31:0] crc;
  logic        err;

  // Beat stage between the pipeline and the output registers; it gives
  // every byte its D+1 cycle latency while the FSM still works on raw inputs.
  logic [7:0]  beat_data;
  logic        beat_valid, beat_last, beat_user;

  // Input bits go in LSB first, and the register is kept in MSB-first order.
  // With this layout a frame with a correct FCS leaves 0xC704DD7B.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : '0);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign len_ext = {16'd0, len};

  always_comb begin
    frame_bad = err
              | (len_ext < MIN_FRAME)
              | (len_ext > MAX_FRAME)
              | (crc != CRC_RESIDUE)
              | (len_ext <= D);
  end

  // A sample with gmii_rx_er high and gmii_rx_dv low is ignored in every state.
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    frame_end  = 1'b0;
    drop_enter = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (!gmii_rx_dv) state_nxt = IDLE;
      end
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PRE_BYTE) begin
            state_nxt = PREAMBLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state_nxt = DATA;
          end else begin
            state_nxt  = DROP;
            drop_enter = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else if (gmii_rx_er) begin
          state_nxt  = DROP;
          drop_enter = 1'b1;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_nxt = DATA;
        end else if (gmii_rxd != PRE_BYTE) begin
          state_nxt  = DROP;
          drop_enter = 1'b1;
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          push = 1'b1;
        end else begin
          frame_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge userclk2) begin
    if (reset) begin
      state         <= WAIT_IDLE;
      for (int unsigned i = 0; i < D; i++) pipe[i] <= '0;
      len           <= '0;
      crc           <= CRC_INIT;
      err           <= 1'b0;
      beat_data     <= '0;
      beat_valid    <= 1'b0;
      beat_last     <= 1'b0;
      beat_user     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frames_ok     <= '0;
      frames_bad    <= '0;
    end else begin
      state         <= state_nxt;
      beat_valid    <= 1'b0;
      beat_last     <= 1'b0;
      beat_user     <= 1'b0;
      m_axis_tdata  <= beat_data;
      m_axis_tvalid <= beat_valid;
      m_axis_tlast  <= beat_last;
      m_axis_tuser  <= beat_user;

      if (push) begin
        pipe[0] <= gmii_rxd;
        for (int unsigned i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        len <= sat_inc(len);
        crc <= crc_byte(crc, gmii_rxd);
        if (gmii_rx_er) err <= 1'b1;
        // Pipeline already full: the oldest byte leaves as the new one enters.
        if (len_ext >= D) begin
          beat_valid <= 1'b1;
          beat_data  <= pipe[OLD];
        end
      end

      if (frame_end) begin
        // A frame of D or fewer bytes has emitted nothing and stays silent.
        if (len_ext > D) begin
          beat_valid <= 1'b1;
          beat_last  <= 1'b1;
          beat_user  <= frame_bad;
          beat_data  <= pipe[OLD];
        end
        if (frame_bad) frames_bad <= sat_inc(frames_bad);
        else           frames_ok  <= sat_inc(frames_ok);
        len <= '0;
        crc <= CRC_INIT;
        err <= 1'b0;
      end else if (drop_enter) begin
        frames_bad <= sat_inc(frames_bad);
      end
    end
  end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 Parameter MAX_FRAME, default 1518, maximum good frame length in bytes after SFD, including FCS.
REQ-002 Parameter MIN_FRAME, default 64, minimum good frame length in bytes after SFD, including FCS.
REQ-003 userclk2  input  1  125 MHz GMII receive clock; the block's only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 gmii_rxd  input  8  receive data from the PCS/PMA core.
REQ-006 gmii_rx_dv  input  1  receive data valid.
REQ-007 gmii_rx_er  input  1  receive error.
REQ-008 m_axis_tdata  output  8  payload byte.
REQ-009 m_axis_tvalid  output  1  beat valid; there is no tready input and no backpressure.
REQ-010 m_axis_tlast  output  1  last beat of a frame.
REQ-011 m_axis_tuser  output  1  frame-bad flag; meaningful only on the tlast beat.
REQ-012 frames_ok  output  16  count of good frames; saturates at 0xFFFF.
REQ-013 frames_bad  output  16  count of bad or dropped frames; saturates at 0xFFFF.

Function
REQ-014 The state machine SHALL have the states WAIT_IDLE, IDLE, PREAMBLE, DATA and DROP.
REQ-015 WAIT_IDLE SHALL move to IDLE on the first sample with gmii_rx_dv=0.
REQ-016 From IDLE, on a sample with gmii_rx_dv=1:
- rxd=0x55 SHALL move to PREAMBLE.
- rxd=0xD5 SHALL move to DATA.
- any other value SHALL move to DROP.
REQ-017 In PREAMBLE:
- rxd=0x55 SHALL stay in PREAMBLE, with no limit on the number of preamble bytes.
- rxd=0xD5 SHALL move to DATA.
- any other byte, or gmii_rx_er=1, SHALL move to DROP.
- gmii_rx_dv=0 SHALL return to IDLE with no count change.
REQ-018 DROP SHALL emit no beats, SHALL increment frames_bad once, and SHALL move to IDLE on gmii_rx_dv=0.
REQ-019 In DATA, every byte sampled with gmii_rx_dv=1 SHALL enter a D-stage hold pipeline.
- D=5 with FCS stripping (REQ-033), otherwise D=1.
REQ-020 When a byte enters the pipeline and the pipeline already holds D bytes, the oldest held byte SHALL be emitted with tvalid=1, tlast=0, tuser=0.
REQ-021 On the first gmii_rx_dv=0 sample in DATA:
- the oldest held byte SHALL be emitted with tlast=1 and tuser equal to the bad flag;
- the counters SHALL update;
- the state SHALL move to IDLE.
REQ-022 Every payload byte SHALL appear on m_axis_tdata exactly D+1 cycles after the edge at which it was sampled, including the tlast byte.
REQ-023 The bad flag SHALL be set by any of:
- gmii_rx_er=1 during DATA;
- a length below MIN_FRAME;
- a length above MAX_FRAME;
- an FCS mismatch.
REQ-024 Oversize frames SHALL be emitted in full and marked bad, not truncated.
REQ-025 Frame length SHALL be counted in a 16-bit saturating counter.
REQ-026 CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL run over every DATA byte including the FCS.
REQ-027 The FCS SHALL be good if and only if the final CRC register equals the residue 0xC704DD7B.
REQ-028 A frame with D or fewer DATA bytes SHALL emit no beats and SHALL increment frames_bad.
REQ-029 gmii_rx_er=1 with gmii_rx_dv=0 (carrier extension or false carrier) SHALL be ignored in every state.
REQ-030 A single idle cycle between frames SHALL be sufficient for back-to-back reception.
REQ-031 All outputs SHALL be registered; m_axis_tvalid SHALL be 0 in every cycle without an emitted beat.

Reset
REQ-032 While reset=1, at the next edge:
- state SHALL become WAIT_IDLE;
- pipeline, CRC and length SHALL clear;
- m_axis_tdata, m_axis_tvalid, m_axis_tlast and m_axis_tuser SHALL be 0;
- frames_ok and frames_bad SHALL be 0.
- A frame in progress when reset asserts or deasserts SHALL produce no beats and no count.

Configuration
REQ-033 Macro GMII_RX_FCS_STRIP_EN:
- Defined: D=5 and the 4 FCS bytes SHALL NOT be emitted.
- Undefined: D=1 and the FCS bytes SHALL be emitted as the last 4 beats.
- The FCS check, the bad flag and the counters SHALL behave identically either way.

Verification
REQ-034 7x0x55, 0xD5, 60-byte payload 0x00..0x3B with valid FCS (strip enabled) -> 60 beats, tlast on 0x3B, tuser=0, frames_ok=1, first beat 6 cycles after its byte was sampled.
REQ-035 Same frame with the last FCS byte inverted -> 60 beats, tuser=1 on tlast, frames_bad=1.
REQ-036 Valid 64-byte frame with gmii_rx_er pulsed on byte 10 -> tuser=1 on tlast, frames_bad=1; separately, a 1519-byte frame -> all 1515 payload beats emitted, tuser=1.
REQ-037 gmii_rx_dv high with first byte 0x12 -> no beats, frames_bad=1; then a valid frame after one idle cycle -> frames_ok=1.
REQ-038 Reset asserted on byte 20 of a frame and released mid-frame -> no beats until gmii_rx_dv falls; the next valid frame is received with frames_ok=1.
REQ-039 Strip disabled (macro undefined), valid 64-byte frame -> 64 beats including FCS, latency 2 cycles, tuser=0.
